// File: rtl/led_seq_gen.sv
// LED pattern sequencer: GRAY / ROTATE / BOUNCE / BAR patterns with a speed-selectable step prescaler.
// Optional macro LED_PWM_EN adds a 4-bit duty input that dims the LEDs with a free-running PWM.
module led_seq_gen #(
   parameter int NUM_LED     = 4,
   parameter int STEP_CYCLES = 50000000,
   parameter int CNT_W       = 31
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               dir,
   input  logic [1:0]         mode,
   input  logic [1:0]         speed,
`ifdef LED_PWM_EN
   input  logic [3:0]         duty,
`endif
   output logic [NUM_LED-1:0] led,
   output logic               step_pulse,
   output logic               wrap
);

   // NUM_LED bits covers the GRAY range and also 0..NUM_LED for BAR (NUM_LED >= 2).
   localparam int POS_W = NUM_LED;

   localparam logic [POS_W-1:0] POS_ZERO = '0;
   localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
   localparam logic [POS_W-1:0] POS_MAX  = '1;
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LED - 1);
   localparam logic [POS_W-1:0] POS_BAR  = POS_W'(NUM_LED);

   typedef enum logic [1:0] {
      MODE_GRAY   = 2'd0,
      MODE_ROTATE = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_BAR    = 2'd3
   } mode_t;

   logic [CNT_W-1:0]   cnt_reg,   cnt_next;
   logic [POS_W-1:0]   pos_reg,   pos_next;
   logic               up_reg,    up_next;
   mode_t              mode_reg,  mode_next;
   logic [NUM_LED-1:0] led_reg,   led_next;
   logic               step_reg,  step_next;
   logic               wrap_reg,  wrap_next;

   logic [POS_W-1:0]   pos_step;
   logic               up_step;
   logic               wrap_step;
   logic [CNT_W-1:0]   period_m1;
   logic [CNT_W-1:0]   period_m1_lut [4];

   // Terminal count per speed setting, computed at elaboration: max(1, STEP_CYCLES >> speed) - 1.
   for (genvar gi = 0; gi < 4; gi++) begin : g_period
      localparam int SHIFTED = STEP_CYCLES >> gi;
      localparam int PERIOD  = (SHIFTED < 1) ? 1 : SHIFTED;
      assign period_m1_lut[gi] = CNT_W'(PERIOD - 1);
   end

   assign period_m1 = period_m1_lut[speed];

   function automatic logic [NUM_LED-1:0] decode(input mode_t m, input logic [POS_W-1:0] p);
      logic [NUM_LED-1:0] v;
      v = '0;
      case (m)
         MODE_GRAY: v = ~(p ^ (p >> 1));
         MODE_ROTATE, MODE_BOUNCE: begin
            for (int i = 0; i < NUM_LED; i++) v[i] = (p == POS_W'(i));
         end
         default: begin
            for (int i = 0; i < NUM_LED; i++) v[i] = (p > POS_W'(i));
         end
      endcase
      return v;
   endfunction

   // Position the pattern would move to if a step fired this cycle.
   always_comb begin
      pos_step  = pos_reg;
      up_step   = up_reg;
      wrap_step = 1'b0;
      case (mode_reg)
         MODE_GRAY: begin
            if (dir) begin
               pos_step  = pos_reg + POS_ONE;
               wrap_step = (pos_reg == POS_MAX);
            end else begin
               pos_step  = pos_reg - POS_ONE;
               wrap_step = (pos_reg == POS_ZERO);
            end
         end
         MODE_ROTATE: begin
            if (dir) begin
               pos_step  = (pos_reg >= POS_LAST) ? POS_ZERO : pos_reg + POS_ONE;
               wrap_step = (pos_reg >= POS_LAST);
            end else begin
               pos_step  = (pos_reg == POS_ZERO) ? POS_LAST : pos_reg - POS_ONE;
               wrap_step = (pos_reg == POS_ZERO);
            end
         end
         MODE_BOUNCE: begin
            // The flag flips on arrival at an end, so the turn-around step needs no special case.
            if (up_reg) begin
               pos_step = pos_reg + POS_ONE;
               if (pos_step >= POS_LAST) up_step = 1'b0;
            end else begin
               pos_step = pos_reg - POS_ONE;
               if (pos_step == POS_ZERO) begin
                  up_step   = 1'b1;
                  wrap_step = 1'b1;
               end
            end
         end
         default: begin
            pos_step  = (pos_reg >= POS_BAR) ? POS_ZERO : pos_reg + POS_ONE;
            wrap_step = (pos_reg >= POS_BAR);
         end
      endcase
   end

   always_comb begin
      cnt_next  = cnt_reg;
      pos_next  = pos_reg;
      up_next   = up_reg;
      mode_next = mode_reg;
      led_next  = led_reg;
      step_next = 1'b0;
      wrap_next = 1'b0;
      if (mode_t'(mode) != mode_reg) begin
         mode_next = mode_t'(mode);
         cnt_next  = '0;
         pos_next  = POS_ZERO;
         up_next   = 1'b1;
         led_next  = decode(mode_t'(mode), POS_ZERO);
      end else if (en) begin
         // >= so that shrinking the period mid-step fires on the next cycle.
         if (cnt_reg >= period_m1) begin
            cnt_next  = '0;
            pos_next  = pos_step;
            up_next   = up_step;
            led_next  = decode(mode_reg, pos_step);
            step_next = 1'b1;
            wrap_next = wrap_step;
         end else begin
            cnt_next = cnt_reg + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_reg  <= '0;
         pos_reg  <= POS_ZERO;
         up_reg   <= 1'b1;
         mode_reg <= mode_t'(mode);
         led_reg  <= '1;
         step_reg <= 1'b0;
         wrap_reg <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         pos_reg  <= pos_next;
         up_reg   <= up_next;
         mode_reg <= mode_next;
         led_reg  <= led_next;
         step_reg <= step_next;
         wrap_reg <= wrap_next;
      end
   end

   assign step_pulse = step_reg;
   assign wrap       = wrap_reg;

`ifdef LED_PWM_EN
   logic [3:0] pwm_cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst) pwm_cnt_reg <= 4'd0;
      else      pwm_cnt_reg <= pwm_cnt_reg + 4'd1;
   end

   assign led = led_reg & {NUM_LED{pwm_cnt_reg < duty}};
`else
   assign led = led_reg;
`endif

endmodule

// File: tb/tb_led_seq_gen.sv
// Bench for led_seq_gen: directed test-plan steps then random control changes, checked every cycle
// against an arithmetic pattern model (NUM_LED=4, STEP_CYCLES=8).
module tb_led_seq_gen;
   localparam int N  = 4;
   localparam int SC = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b1;
   logic         dir = 1'b1;
   logic [1:0]   mode = 2'd0;
   logic [1:0]   speed = 2'd0;
   logic [N-1:0] led;
   logic         step_pulse;
   logic         wrap;
`ifdef LED_PWM_EN
   logic [3:0]   duty = 4'd4;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Model state: k is a step index (triangle phase for BOUNCE), not the RTL position register.
   int       m_cnt = 0;
   int       m_k = 0;
   int       m_mode = 0;
   int       m_pwm = 0;
   bit [3:0] m_led = 4'hF;
   bit       m_step = 0;
   bit       m_wrap = 0;

   led_seq_gen #(.NUM_LED(N), .STEP_CYCLES(SC), .CNT_W(4)) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .dir(dir),
      .mode(mode),
      .speed(speed),
`ifdef LED_PWM_EN
      .duty(duty),
`endif
      .led(led),
      .step_pulse(step_pulse),
      .wrap(wrap)
   );

   always #5 clk = ~clk;

   function automatic bit [3:0] led_of(input int m, input int k);
      bit [3:0] kk;
      int p;
      kk = 4'(k);
      case (m)
         0: return ~(kk ^ (kk >> 1));
         1: return 4'(1 << k);
         2: begin
            p = (k < N) ? k : 2 * N - 2 - k;
            return 4'(1 << p);
         end
         default: return 4'((1 << k) - 1);
      endcase
   endfunction

   task automatic model_edge();
      int period;
      int nk;
      m_step = 0;
      m_wrap = 0;
      m_pwm  = rst ? (m_pwm + 1) % 16 : 0;
      if (!rst) begin
         m_cnt = 0; m_k = 0; m_mode = int'(mode); m_led = 4'hF;
      end else if (int'(mode) != m_mode) begin
         m_mode = int'(mode); m_cnt = 0; m_k = 0; m_led = led_of(m_mode, 0);
      end else if (en) begin
         period = SC >> speed;
         if (period < 1) period = 1;
         if (m_cnt >= period - 1) begin
            m_cnt  = 0;
            m_step = 1;
            case (m_mode)
               0: begin
                  nk = (m_k + (dir ? 1 : 15)) % 16;
                  m_wrap = dir ? (nk == 0) : (m_k == 0);
               end
               1: begin
                  nk = (m_k + (dir ? 1 : N - 1)) % N;
                  m_wrap = dir ? (nk == 0) : (m_k == 0);
               end
               2: begin
                  nk = (m_k + 1) % (2 * N - 2);
                  m_wrap = (nk == 0);
               end
               default: begin
                  nk = (m_k + 1) % (N + 1);
                  m_wrap = (nk == 0);
               end
            endcase
            m_k   = nk;
            m_led = led_of(m_mode, m_k);
         end else begin
            m_cnt++;
         end
      end
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h (t=%0t mode=%0d)", tag, obs, exp, $time, m_mode);
      end
   endtask

   task automatic tick();
      bit [3:0] exp_led;
      @(posedge clk);
      model_edge();
      #1;
      exp_led = m_led;
`ifdef LED_PWM_EN
      if (!(m_pwm < int'(duty))) exp_led = 4'h0;
`endif
      check("led", 16'(led), 16'(exp_led));
      check("step_pulse", 16'(step_pulse), 16'(m_step));
      check("wrap", 16'(wrap), 16'(m_wrap));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      // Reset, then GRAY forward for a full 16-step cycle.
      rst = 1'b0; mode = 2'd0; dir = 1'b1; speed = 2'd0; en = 1'b1;
      run(2);
      rst = 1'b1;
      run(SC * 16 + 4);
      // Reset mid-step aborts the step.
      run(3);
      rst = 1'b0; run(1);
      rst = 1'b1; dir = 1'b0;
      run(SC * 3);
      // ROTATE forward, then reverse.
      mode = 2'd1; dir = 1'b1;
      run(SC * 5 + 2);
      dir = 1'b0;
      run(SC * 3);
      // BOUNCE then BAR.
      mode = 2'd2;
      run(SC * 8);
      mode = 2'd3;
      run(SC * 6);
      // Speed: every-cycle stepping, then shrink the period at cnt=5.
      speed = 2'd3;
      run(10);
      speed = 2'd0; rst = 1'b0; run(1);
      rst = 1'b1; run(5);
      speed = 2'd1; run(6);
      // Freeze.
      en = 1'b0; run(20);
      en = 1'b1; run(4);
      // Mode change mid-step.
      speed = 2'd0; mode = 2'd0; run(3);
      mode = 2'd1; run(3);

      // Random control changes; mode only changes on enabled cycles.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 9) == 0) en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 29) == 0) dir = 1'($urandom);
         if ($urandom_range(0, 39) == 0) speed = 2'($urandom);
         if ($urandom_range(0, 79) == 0) begin
            mode = 2'($urandom);
            en = 1'b1;
         end
`ifdef LED_PWM_EN
         if ($urandom_range(0, 99) == 0) duty = 4'($urandom);
`endif
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
